eth_rx_packet_tracker: RTL and testbench
========================================

// Module: eth_rx_packet_tracker
//
// PURPOSE
// Tracks completed frames in the RX packet buffer: the MAC commits a frame (slot + length), the CPU
// releases the oldest one. Holds a circular queue of per-slot lengths, tells the MAC which slot to
// fill next, and drives rx_ready_o into the interrupt generator's rx_ready_i. The CPU's "clear RX
// pending" write arrives here as rx_release_i and frees exactly one frame.
//
// PARAMETERS
// els_p           2   number of RX buffer slots; power of two, >= 2
// len_width_p     11  frame length width in bytes (1518 fits)
// cnt_width_p     16  width of the saturating drop and error statistics counters
//
// PORTS
// clk_i            in   1                  clock
// reset_i          in   1                  synchronous, active-high reset
// pkt_slot_o       out  $clog2(els_p)      slot the MAC writes next (tail pointer)
// pkt_slot_avail_o out  1                  1 = free slot exists (count < els_p)
// pkt_done_v_i     in   1                  MAC finished the frame in pkt_slot_o
// pkt_len_i        in   len_width_p        byte length of that frame, valid with pkt_done_v_i
// pkt_err_i        in   1                  frame bad (FCS/runt), valid with pkt_done_v_i
// pkt_drop_i       in   1                  MAC dropped a frame because pkt_slot_avail_o was 0
// rx_ready_o       out  1                  >= 1 committed frame waiting (count != 0)
// rx_head_slot_o   out  $clog2(els_p)      slot of oldest frame (head pointer)
// rx_head_len_o    out  len_width_p        length of oldest frame; 0 when rx_ready_o = 0
// rx_release_i     in   1                  CPU frees the oldest frame (one pulse = one frame)
// stat_clear_i     in   1                  zero both statistics counters
// drop_count_o     out  cnt_width_p        frames dropped for lack of a slot
// err_count_o      out  cnt_width_p        frames discarded as bad
//
// BEHAVIOUR
// - State: head_r, tail_r ($clog2(els_p) bits, wrap modulo els_p), count_r (0..els_p, $clog2(els_p)+1
//   bits), len_r[els_p], drop_r, err_r. All registered; all outputs combinational from these regs.
// - Reset: head_r = tail_r = count_r = 0, counters 0, len_r contents 0. So rx_ready_o = 0,
//   pkt_slot_avail_o = 1, pkt_slot_o = 0, rx_head_slot_o = 0, rx_head_len_o = 0, counts 0.
//   Reset mid-operation discards every queued frame; reset wins over all other inputs.
// - push = pkt_done_v_i & ~pkt_err_i & pkt_slot_avail_o: len_r[tail_r] <= pkt_len_i, tail_r++.
// - pkt_done_v_i & pkt_err_i: no enqueue, tail_r unchanged (slot reused), err_r++.
// - pkt_done_v_i while pkt_slot_avail_o = 0 is a protocol error: ignored, simulation assertion fires.
// - pop = rx_release_i & rx_ready_o: head_r++. rx_release_i when empty: no-op, no underflow.
// - count_r: +1 on push only, -1 on pop only, unchanged on push & pop together (both pointers advance).
// - Latency: a push raises rx_ready_o on the next cycle; a pop of the last frame drops it next cycle.
//   Release when full raises pkt_slot_avail_o next cycle; no same-cycle bypass in either direction.
// - Counters saturate at all-ones (no wrap). pkt_drop_i -> drop_r++. stat_clear_i beats a
//   same-cycle increment (result 0).
// - head_r == tail_r is ambiguous; full/empty decided only by count_r.
// - pkt_drop_i and pkt_err_i may be asserted in the same cycle; each counter updates independently.
//
// TESTING
// 1 Reset, push len 64 then len 1518 (els_p=2) -> avail 0 after 2nd push; head_len 64; rx_ready 1.
// 2 Full, rx_release_i 1 cycle -> next cycle head_slot 1, head_len 1518, avail 1, pkt_slot_o 0.
// 3 count=1, push len 100 and release same cycle -> count stays 1, head_len 100, both ptrs advanced.
// 4 Empty, rx_release_i pulsed 3x -> rx_ready 0, head/tail 0, no assertion, counts unchanged.
// 5 pkt_done_v_i+pkt_err_i -> err_count 1, no enqueue; cnt_width_p=4 with 20 pkt_drop_i -> drop 15.
// 6 Full queue, reset_i mid-traffic -> next cycle rx_ready 0, avail 1, all pointers and counters 0.

Source files
------------

// File: rtl/eth_rx_packet_tracker_if.sv
// Bus between the RX packet tracker and its MAC/CPU clients.
// master = MAC/CPU side, slave = tracker side.
interface eth_rx_packet_tracker_if #(
  parameter int els_p       = 2,
  parameter int len_width_p = 11,
  parameter int cnt_width_p = 16
);
  localparam int ptr_w = $clog2(els_p);

  logic [ptr_w-1:0]       pkt_slot_o;
  logic                   pkt_slot_avail_o;
  logic                   pkt_done_v_i;
  logic [len_width_p-1:0] pkt_len_i;
  logic                   pkt_err_i;
  logic                   pkt_drop_i;
  logic                   rx_ready_o;
  logic [ptr_w-1:0]       rx_head_slot_o;
  logic [len_width_p-1:0] rx_head_len_o;
  logic                   rx_release_i;
  logic                   stat_clear_i;
  logic [cnt_width_p-1:0] drop_count_o;
  logic [cnt_width_p-1:0] err_count_o;

  modport master (
    input  pkt_slot_o, pkt_slot_avail_o, rx_ready_o, rx_head_slot_o, rx_head_len_o,
           drop_count_o, err_count_o,
    output pkt_done_v_i, pkt_len_i, pkt_err_i, pkt_drop_i, rx_release_i, stat_clear_i
  );

  modport slave (
    output pkt_slot_o, pkt_slot_avail_o, rx_ready_o, rx_head_slot_o, rx_head_len_o,
           drop_count_o, err_count_o,
    input  pkt_done_v_i, pkt_len_i, pkt_err_i, pkt_drop_i, rx_release_i, stat_clear_i
  );
endinterface

// File: rtl/eth_rx_packet_tracker.sv
// Circular queue of committed RX frame lengths: MAC pushes at the tail, CPU releases from the head.
// Also keeps saturating drop/error statistics.
module eth_rx_packet_tracker #(
  parameter int els_p       = 2,
  parameter int len_width_p = 11,
  parameter int cnt_width_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  eth_rx_packet_tracker_if.slave  bus
);
  localparam int ptr_w = $clog2(els_p);

  logic [ptr_w-1:0]       head_reg;
  logic [ptr_w-1:0]       tail_reg;
  logic [ptr_w:0]         count_reg;
  logic [len_width_p-1:0] len_reg [els_p];
  logic [cnt_width_p-1:0] drop_reg;
  logic [cnt_width_p-1:0] err_reg;

  logic avail;
  logic ready;
  logic push;
  logic pop;
  logic err_hit;

  assign avail   = (count_reg != (ptr_w + 1)'(els_p));
  assign ready   = (count_reg != '0);
  assign push    = bus.pkt_done_v_i & ~bus.pkt_err_i & avail;
  assign pop     = bus.rx_release_i & ready;
  // A bad frame leaves the tail alone so the MAC simply refills the same slot.
  assign err_hit = bus.pkt_done_v_i & bus.pkt_err_i & avail;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < els_p; gi++) begin : g_len
      always_ff @(posedge clk_i) begin
        if (reset_i)
          len_reg[gi] <= '0;
        else if (push && (tail_reg == ptr_w'(gi)))
          len_reg[gi] <= bus.pkt_len_i;
      end
    end
  endgenerate

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk_i) begin
    if (reset_i || bus.stat_clear_i) begin
      drop_reg <= '0;
      err_reg  <= '0;
    end else begin
      if (bus.pkt_drop_i && !(&drop_reg)) drop_reg <= drop_reg + 1'b1;
      if (err_hit && !(&err_reg))         err_reg  <= err_reg + 1'b1;
    end
  end

  assign bus.pkt_slot_o       = tail_reg;
  assign bus.pkt_slot_avail_o = avail;
  assign bus.rx_ready_o       = ready;
  assign bus.rx_head_slot_o   = head_reg;
  assign bus.rx_head_len_o    = ready ? len_reg[head_reg] : '0;
  assign bus.drop_count_o     = drop_reg;
  assign bus.err_count_o      = err_reg;

  // Completing a frame with no free slot is a MAC protocol violation.
  no_done_when_full : assert property (@(posedge clk_i) disable iff (reset_i)
    !(bus.pkt_done_v_i && !avail));
endmodule

// File: tb/tb_eth_rx_packet_tracker.sv
// Randomized + directed check of eth_rx_packet_tracker against a queue-based reference model.
// A second instance with 4-bit counters checks drop-counter saturation.
module tb_eth_rx_packet_tracker;
  localparam int E = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_rx_packet_tracker_if #(.els_p(E), .len_width_p(11), .cnt_width_p(16)) bus_a ();
  eth_rx_packet_tracker_if #(.els_p(E), .len_width_p(11), .cnt_width_p(4))  bus_b ();

  eth_rx_packet_tracker #(.els_p(E), .len_width_p(11), .cnt_width_p(16)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus(bus_a.slave));
  eth_rx_packet_tracker #(.els_p(E), .len_width_p(11), .cnt_width_p(4)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus(bus_b.slave));

  // Reference model: frames waiting, slot indices, statistics.
  int q[$];
  int hs, ts, m_drop, m_err, m_drop_b;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rx_ready"}, 32'(bus_a.rx_ready_o), 32'(q.size() != 0));
    chk({tag, ".avail"}, 32'(bus_a.pkt_slot_avail_o), 32'(q.size() < E));
    chk({tag, ".pkt_slot"}, 32'(bus_a.pkt_slot_o), 32'(ts));
    chk({tag, ".head_slot"}, 32'(bus_a.rx_head_slot_o), 32'(hs));
    chk({tag, ".head_len"}, 32'(bus_a.rx_head_len_o), 32'(q.size() != 0 ? q[0] : 0));
    chk({tag, ".drop"}, 32'(bus_a.drop_count_o), 32'(m_drop));
    chk({tag, ".err"}, 32'(bus_a.err_count_o), 32'(m_err));
    chk({tag, ".drop_b"}, 32'(bus_b.drop_count_o), 32'(m_drop_b));
  endtask

  task automatic step(input string tag, input bit r, input bit done, input int len,
                      input bit err, input bit drop, input bit rel, input bit clr,
                      input bit drop_b);
    bit can_push, can_pop;
    rst = r;
    bus_a.pkt_done_v_i = done;
    bus_a.pkt_len_i    = 11'(len);
    bus_a.pkt_err_i    = err;
    bus_a.pkt_drop_i   = drop;
    bus_a.rx_release_i = rel;
    bus_a.stat_clear_i = clr;
    bus_b.pkt_drop_i   = drop_b;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_a.pkt_done_v_i = 1'b0;
    bus_a.pkt_err_i    = 1'b0;
    bus_a.pkt_drop_i   = 1'b0;
    bus_a.rx_release_i = 1'b0;
    bus_a.stat_clear_i = 1'b0;
    bus_b.pkt_drop_i   = 1'b0;
    if (r) begin
      q.delete();
      hs = 0; ts = 0; m_drop = 0; m_err = 0; m_drop_b = 0;
    end else begin
      can_push = done && !err && (q.size() < E);
      can_pop  = rel && (q.size() != 0);
      if (can_pop) begin
        void'(q.pop_front());
        hs = (hs + 1) % E;
      end
      if (can_push) begin
        q.push_back(len);
        ts = (ts + 1) % E;
      end
      if (clr) begin
        m_drop = 0; m_err = 0;
      end else begin
        if (drop) m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
        if (done && err) m_err = (m_err < 65535) ? m_err + 1 : m_err;
      end
      if (drop_b) m_drop_b = (m_drop_b < 15) ? m_drop_b + 1 : m_drop_b;
    end
    check_all(tag);
  endtask

  initial begin
    bus_a.pkt_len_i = '0;
    bus_b.pkt_done_v_i = 1'b0;
    bus_b.pkt_len_i    = '0;
    bus_b.pkt_err_i    = 1'b0;
    bus_b.rx_release_i = 1'b0;
    bus_b.stat_clear_i = 1'b0;

    // 1: reset, then two pushes fill the queue
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    step("push64", 0, 1, 64, 0, 0, 0, 0, 0);
    step("push1518", 0, 1, 1518, 0, 0, 0, 0, 0);
    chk("full.avail_low", 32'(bus_a.pkt_slot_avail_o), 32'd0);
    chk("full.head_len", 32'(bus_a.rx_head_len_o), 32'd64);
    // 2: release when full
    step("rel_full", 0, 0, 0, 0, 0, 1, 0, 0);
    chk("rel_full.head_len", 32'(bus_a.rx_head_len_o), 32'd1518);
    // 3: push and release together at count 1
    step("push_pop", 0, 1, 100, 0, 0, 1, 0, 0);
    chk("push_pop.head_len", 32'(bus_a.rx_head_len_o), 32'd100);
    // 4: release on empty is a no-op
    step("reset2", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("rel_empty", 0, 0, 0, 0, 0, 1, 0, 0);
    // 5: bad frame, then 20 drops saturate the 4-bit counter
    step("err_frame", 0, 1, 77, 1, 0, 0, 0, 0);
    chk("err_frame.err1", 32'(bus_a.err_count_o), 32'd1);
    for (int i = 0; i < 20; i++) step("drop_sat", 0, 0, 0, 0, 1, 0, 0, 1);
    chk("drop_sat.b15", 32'(bus_b.drop_count_o), 32'd15);
    step("clr_vs_inc", 0, 1, 5, 1, 1, 0, 1, 0);
    // 6: reset with a full queue and live traffic
    step("fill_a", 0, 1, 300, 0, 1, 0, 0, 1);
    step("fill_b", 0, 1, 400, 1, 1, 0, 0, 0);
    step("fill_c", 0, 1, 500, 0, 0, 0, 0, 0);
    step("reset_mid", 1, 0, 0, 0, 1, 1, 0, 1);

    // Randomized traffic; never complete a frame into a full queue.
    for (int i = 0; i < 400; i++) begin
      bit done, err;
      done = ($urandom_range(0, 1) == 1) && (q.size() < E);
      err  = ($urandom_range(0, 3) == 0);
      step("rand", 0, done, int'($urandom_range(1, 1518)), err,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 30) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
